// File: rtl/trap_controller.sv
// Machine-mode trap sequencer. Owns mstatus/mie/mtvec/mepc/mcause/mip and the current
// privilege level. Sequences exception/interrupt entry (IDLE -> SAVE -> VECTOR) and
// MRET return (IDLE -> RESTORE), stalling the core and issuing a one-cycle redirect.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   instrValid, pc      instruction in decode this cycle and its address
//   exception, excCode  decoder exception strobe and code
//   mret                decoder MRET strobe
//   irq[2:0]            level interrupts: [0] software, [1] timer, [2] external
//   csrAddr/csrWrData/csrWr/csrRdData  CSR access port (read is combinational)
//   stall               freeze fetch/writeback
//   redirect/redirectPC load redirectPC into PC this cycle
//   privilegeLevel      2'b11 machine, 2'b00 user
module trap_controller #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instrValid,
    input  logic [31:0] pc,
    input  logic        exception,
    input  logic [30:0] excCode,
    input  logic        mret,
    input  logic [2:0]  irq,
    input  logic [11:0] csrAddr,
    input  logic [31:0] csrWrData,
    input  logic        csrWr,
    output logic [31:0] csrRdData,
    output logic        stall,
    output logic        redirect,
    output logic [31:0] redirectPC,
    output logic [1:0]  privilegeLevel
);

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MIE     = 12'h304;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MIP     = 12'h344;

    localparam logic [1:0] PRIV_M = 2'b11;
    localparam logic [1:0] PRIV_U = 2'b00;

    typedef enum logic [1:0] {StIdle, StSave, StVector, StRestore} state_e;

    state_e      state_q, state_d;
    logic [1:0]  priv_q, priv_d;
    logic        st_mie_q, st_mie_d;
    logic        st_mpie_q, st_mpie_d;
    logic [1:0]  st_mpp_q, st_mpp_d;
    logic [2:0]  mie_q, mie_d;         // enables for bits 3/7/11
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] epc_q, epc_d;         // trap PC held between detect and SAVE
    logic [31:0] cause_q, cause_d;
    logic [2:0]  sync_q [SYNC_STAGES];

    logic [2:0]  mip;
    logic [2:0]  irq_active;
    logic        irq_pending;
    logic [3:0]  irq_code;
    logic        det_exc, det_irq, det_mret, detect;
    logic [31:0] vec_base;

    assign mip        = sync_q[SYNC_STAGES-1];
    assign irq_active = mip & mie_q;
    // User mode takes machine interrupts regardless of MIE.
    assign irq_pending = (|irq_active) && (st_mie_q || (priv_q == PRIV_U));

    always_comb begin
        irq_code = 4'd7;
        if (irq_active[2]) begin
            irq_code = 4'd11;
        end else if (irq_active[0]) begin
            irq_code = 4'd3;
        end
    end

    assign det_exc  = (state_q == StIdle) && instrValid && exception;
    assign det_irq  = (state_q == StIdle) && instrValid && !exception && irq_pending;
    assign det_mret = (state_q == StIdle) && instrValid && !exception && !irq_pending && mret;
    assign detect   = det_exc || det_irq || det_mret;

    assign stall          = detect || (state_q != StIdle);
    assign privilegeLevel = priv_q;
    assign vec_base       = {mtvec_q[31:2], 2'b00};

    always_comb begin
        redirect   = 1'b0;
        redirectPC = 32'h0;
        unique case (state_q)
            StVector: begin
                redirect = 1'b1;
                if (mtvec_q[0] && cause_q[31]) begin
                    redirectPC = vec_base + {cause_q[29:0], 2'b00};
                end else begin
                    redirectPC = vec_base;
                end
            end
            StRestore: begin
                redirect   = 1'b1;
                redirectPC = mepc_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        csrRdData = 32'h0;
        unique case (csrAddr)
            ADDR_MSTATUS: csrRdData = {19'b0, st_mpp_q, 3'b0, st_mpie_q, 3'b0, st_mie_q, 3'b0};
            ADDR_MIE:     csrRdData = {20'b0, mie_q[2], 3'b0, mie_q[1], 3'b0, mie_q[0], 3'b0};
            ADDR_MTVEC:   csrRdData = mtvec_q;
            ADDR_MEPC:    csrRdData = mepc_q;
            ADDR_MCAUSE:  csrRdData = mcause_q;
            ADDR_MIP:     csrRdData = {20'b0, mip[2], 3'b0, mip[1], 3'b0, mip[0], 3'b0};
            default:      csrRdData = 32'h0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        priv_d    = priv_q;
        st_mie_d  = st_mie_q;
        st_mpie_d = st_mpie_q;
        st_mpp_d  = st_mpp_q;
        mie_d     = mie_q;
        mtvec_d   = mtvec_q;
        mepc_d    = mepc_q;
        mcause_d  = mcause_q;
        epc_d     = epc_q;
        cause_d   = cause_q;

        unique case (state_q)
            StIdle: begin
                if (det_exc) begin
                    epc_d   = pc;
                    cause_d = {1'b0, excCode};
                    state_d = StSave;
                end else if (det_irq) begin
                    epc_d   = pc;
                    cause_d = {1'b1, 27'b0, irq_code};
                    state_d = StSave;
                end else if (det_mret) begin
                    state_d = StRestore;
                end else if (csrWr) begin
                    unique case (csrAddr)
                        ADDR_MSTATUS: begin
                            st_mie_d  = csrWrData[3];
                            st_mpie_d = csrWrData[7];
                            st_mpp_d  = csrWrData[12:11];
                        end
                        ADDR_MIE:    mie_d    = {csrWrData[11], csrWrData[7], csrWrData[3]};
                        ADDR_MTVEC:  mtvec_d  = {csrWrData[31:2], 1'b0, csrWrData[0]};
                        ADDR_MEPC:   mepc_d   = {csrWrData[31:2], 2'b00};
                        ADDR_MCAUSE: mcause_d = csrWrData;
                        default: ;
                    endcase
                end
            end
            StSave: begin
                mepc_d    = {epc_q[31:2], 2'b00};
                mcause_d  = cause_q;
                st_mpie_d = st_mie_q;
                st_mie_d  = 1'b0;
                st_mpp_d  = priv_q;
                priv_d    = PRIV_M;
                state_d   = StVector;
            end
            StVector: begin
                state_d = StIdle;
            end
            StRestore: begin
                st_mie_d  = st_mpie_q;
                st_mpie_d = 1'b1;
                priv_d    = st_mpp_q;
                st_mpp_d  = PRIV_U;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            priv_q    <= PRIV_M;
            st_mie_q  <= 1'b0;
            st_mpie_q <= 1'b0;
            st_mpp_q  <= 2'b00;
            mie_q     <= 3'b000;
            mtvec_q   <= {MTVEC_RESET[31:2], 1'b0, MTVEC_RESET[0]};
            mepc_q    <= 32'h0;
            mcause_q  <= 32'h0;
            epc_q     <= 32'h0;
            cause_q   <= 32'h0;
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= 3'b000;
            end
        end else begin
            state_q   <= state_d;
            priv_q    <= priv_d;
            st_mie_q  <= st_mie_d;
            st_mpie_q <= st_mpie_d;
            st_mpp_q  <= st_mpp_d;
            mie_q     <= mie_d;
            mtvec_q   <= mtvec_d;
            mepc_q    <= mepc_d;
            mcause_q  <= mcause_d;
            epc_q     <= epc_d;
            cause_q   <= cause_d;
            sync_q[0] <= irq;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller: reset state, ECALL entry, vectored interrupt,
// exception/interrupt priority, MRET return, reset mid-sequence, CSR write blocking.
module tb_trap_controller;

    logic        clk;
    logic        reset;
    logic        instrValid;
    logic [31:0] pc;
    logic        exception;
    logic [30:0] excCode;
    logic        mret;
    logic [2:0]  irq;
    logic [11:0] csrAddr;
    logic [31:0] csrWrData;
    logic        csrWr;
    logic [31:0] csrRdData;
    logic        stall;
    logic        redirect;
    logic [31:0] redirectPC;
    logic [1:0]  privilegeLevel;

    int total = 0;
    int bad   = 0;

    trap_controller #(
        .MTVEC_RESET(32'h0000_0000),
        .SYNC_STAGES(2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .instrValid    (instrValid),
        .pc            (pc),
        .exception     (exception),
        .excCode       (excCode),
        .mret          (mret),
        .irq           (irq),
        .csrAddr       (csrAddr),
        .csrWrData     (csrWrData),
        .csrWr         (csrWr),
        .csrRdData     (csrRdData),
        .stall         (stall),
        .redirect      (redirect),
        .redirectPC    (redirectPC),
        .privilegeLevel(privilegeLevel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_rd(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        csrAddr = addr;
        #1;
        chk(tag, csrRdData, exp);
    endtask

    task automatic csr_wr(input logic [11:0] addr, input logic [31:0] data);
        csrAddr   = addr;
        csrWrData = data;
        csrWr     = 1'b1;
        step();
        csrWr     = 1'b0;
    endtask

    task automatic issue(input logic [31:0] a, input logic exc, input logic [30:0] code,
                         input logic is_mret);
        pc         = a;
        exception  = exc;
        excCode    = code;
        mret       = is_mret;
        instrValid = 1'b1;
        #1;
    endtask

    task automatic retire();
        instrValid = 1'b0;
        exception  = 1'b0;
        mret       = 1'b0;
    endtask

    initial begin
        reset = 1'b0; instrValid = 1'b0; pc = 32'h0; exception = 1'b0; excCode = 31'h0;
        mret = 1'b0; irq = 3'b000; csrAddr = 12'h0; csrWrData = 32'h0; csrWr = 1'b0;
        step(); step();
        reset = 1'b1;
        step();

        // Reset state
        chk("rst_priv", {30'b0, privilegeLevel}, 32'h3);
        chk("rst_stall", {31'b0, stall}, 32'h0);
        chk("rst_redirect", {31'b0, redirect}, 32'h0);
        csr_rd("rst_mtvec", 12'h305, 32'h0);
        csr_rd("rst_mstatus", 12'h300, 32'h0);
        csr_rd("rst_mepc", 12'h341, 32'h0);
        csr_rd("rst_mcause", 12'h342, 32'h0);

        // Unmapped address: write ignored, reads 0
        csr_wr(12'h7C0, 32'hDEAD_BEEF);
        csr_rd("unmapped", 12'h7C0, 32'h0);

        // ECALL with MIE set beforehand
        csr_wr(12'h305, 32'h200);
        csr_wr(12'h300, 32'h8);
        issue(32'h100, 1'b1, 31'd8, 1'b0);
        chk("ecall_c1_stall", {31'b0, stall}, 32'h1);
        chk("ecall_c1_redir", {31'b0, redirect}, 32'h0);
        step(); retire(); #1;
        chk("ecall_c2_stall", {31'b0, stall}, 32'h1);
        chk("ecall_c2_redir", {31'b0, redirect}, 32'h0);
        step();
        chk("ecall_c3_stall", {31'b0, stall}, 32'h1);
        chk("ecall_c3_redir", {31'b0, redirect}, 32'h1);
        chk("ecall_target", redirectPC, 32'h200);
        csr_rd("ecall_mepc", 12'h341, 32'h100);
        csr_rd("ecall_mcause", 12'h342, 32'h8);
        csr_rd("ecall_mstatus", 12'h300, 32'h1880);
        step();
        chk("ecall_done_stall", {31'b0, stall}, 32'h0);
        chk("ecall_done_redir", {31'b0, redirect}, 32'h0);
        chk("ecall_priv", {30'b0, privilegeLevel}, 32'h3);

        // Vectored timer interrupt
        csr_wr(12'h305, 32'h401);
        csr_wr(12'h304, 32'h80);
        csr_wr(12'h300, 32'h8);
        csr_rd("vec_mtvec", 12'h305, 32'h401);
        csr_rd("vec_mie", 12'h304, 32'h80);
        irq = 3'b010;
        step();
        csr_rd("mip_1clk", 12'h344, 32'h0);
        step();
        csr_rd("mip_2clk", 12'h344, 32'h80);
        issue(32'h50, 1'b0, 31'd0, 1'b0);
        chk("tmr_c1_stall", {31'b0, stall}, 32'h1);
        step(); retire(); #1;
        step();
        chk("tmr_redir", {31'b0, redirect}, 32'h1);
        chk("tmr_target", redirectPC, 32'h41C);
        csr_rd("tmr_mcause", 12'h342, 32'h8000_0007);
        csr_rd("tmr_mepc", 12'h341, 32'h50);
        step();
        chk("tmr_done_stall", {31'b0, stall}, 32'h0);
        irq = 3'b000;

        // Priority: exception beats pending external interrupt
        csr_wr(12'h304, 32'h800);
        csr_wr(12'h300, 32'h8);
        irq = 3'b100;
        step(); step();
        issue(32'h60, 1'b1, 31'd2, 1'b0);
        step(); retire(); #1;
        step();
        csr_rd("prio_exc_mcause", 12'h342, 32'h2);
        chk("prio_exc_target", redirectPC, 32'h400);
        step();
        csr_wr(12'h300, 32'h8);
        issue(32'h64, 1'b0, 31'd0, 1'b0);
        chk("prio_irq_stall", {31'b0, stall}, 32'h1);
        step(); retire(); #1;
        step();
        csr_rd("prio_irq_mcause", 12'h342, 32'h8000_000B);
        chk("prio_irq_target", redirectPC, 32'h42C);
        step();
        irq = 3'b000;
        step(); step();

        // MRET to user mode
        csr_wr(12'h341, 32'h123);
        csr_wr(12'h300, 32'h80);
        csr_rd("mret_mepc", 12'h341, 32'h120);
        issue(32'h70, 1'b0, 31'd0, 1'b1);
        chk("mret_c1_stall", {31'b0, stall}, 32'h1);
        chk("mret_c1_redir", {31'b0, redirect}, 32'h0);
        step(); retire(); #1;
        chk("mret_c2_redir", {31'b0, redirect}, 32'h1);
        chk("mret_target", redirectPC, 32'h120);
        step();
        chk("mret_done_stall", {31'b0, stall}, 32'h0);
        chk("mret_priv", {30'b0, privilegeLevel}, 32'h0);
        csr_rd("mret_mstatus", 12'h300, 32'h88);

        // ECALL from user mode saves MPP = 00
        issue(32'h80, 1'b1, 31'd8, 1'b0);
        step(); retire(); #1;
        step();
        csr_rd("uecall_mcause", 12'h342, 32'h8);
        csr_rd("uecall_mstatus", 12'h300, 32'h80);
        chk("uecall_priv", {30'b0, privilegeLevel}, 32'h3);
        step();

        // Reset pulsed during SAVE
        issue(32'h90, 1'b1, 31'd2, 1'b0);
        step(); retire(); #1;
        chk("save_stall", {31'b0, stall}, 32'h1);
        reset = 1'b0;
        #1;
        chk("rstmid_stall", {31'b0, stall}, 32'h0);
        chk("rstmid_redir", {31'b0, redirect}, 32'h0);
        #2;
        reset = 1'b1;
        step();
        chk("rstmid_after_redir", {31'b0, redirect}, 32'h0);
        chk("rstmid_after_stall", {31'b0, stall}, 32'h0);
        csr_rd("rstmid_mepc", 12'h341, 32'h0);

        // CSR write during VECTOR is ignored
        csr_wr(12'h305, 32'h300);
        issue(32'hA0, 1'b1, 31'd8, 1'b0);
        step(); retire(); #1;
        step();
        chk("vecwr_redir", {31'b0, redirect}, 32'h1);
        csrAddr = 12'h305; csrWrData = 32'h0000_FFF0; csrWr = 1'b1;
        #1;
        chk("vecwr_target", redirectPC, 32'h300);
        step();
        csrWr = 1'b0;
        csr_rd("vecwr_mtvec", 12'h305, 32'h300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/trap_controller.md
Name: trap_controller

Overview:
- Machine-mode trap sequencer beside the instruction decoder.
- Takes the decoder's exception, excCode and mret strobes, plus level interrupt lines.
- Owns the trap CSRs and the current privilege level.
- Stalls the core while it saves or restores state, then issues a one-cycle PC redirect to the trap vector or to mepc.

Parameters:
MTVEC_RESET, 32'h0000_0000, reset value of mtvec
SYNC_STAGES, 2, flop stages synchronising irq into mip (min 1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
instrValid  in  1  instruction at pc is in decode this cycle
pc  in  32  address of that instruction
exception  in  1  decoder exception strobe
excCode  in  31  decoder exception code
mret  in  1  decoder MRET strobe
irq  in  3  level interrupts: [0] software, [1] timer, [2] external
csrAddr  in  12  CSR address
csrWrData  in  32  CSR write data
csrWr  in  1  CSR write enable
csrRdData  out  32  combinational CSR read data
stall  out  1  freeze fetch/writeback
redirect  out  1  load redirectPC into PC this cycle
redirectPC  out  32  redirect target
privilegeLevel  out  2  11 = machine, 00 = user

Behaviour:
- Reset (async, reset low): state IDLE; priv 11; mtvec = MTVEC_RESET; mstatus, mie, mepc, mcause, sync flops = 0; stall, redirect, redirectPC = 0.
- Reset asserted mid-sequence aborts the sequence. No redirect is issued.
- CSR map, read combinationally:
  - mstatus 0x300: MIE bit3, MPIE bit7, MPP bits12:11; other bits 0.
  - mie 0x304: bits 3/7/11 writable.
  - mtvec 0x305: bit1 forced 0.
  - mepc 0x341: bits1:0 read 0.
  - mcause 0x342.
  - mip 0x344: read-only; bits 3/7/11 = synchronised irq[0]/[1]/[2].
  - Unmapped addresses read 0; writes to them are ignored.
- irq reaches mip after SYNC_STAGES clocks.
- Interrupt pending: (mip & mie) != 0 and (mstatus.MIE or priv == 00).
  - Priority: external (cause 11) > software (3) > timer (7).
- Trap detect, IDLE only, requires instrValid. Priority: exception > pending interrupt > mret.
- Same-cycle outputs: stall = detect or state != IDLE. Decoder writes for that instruction are suppressed by stall.
- IDLE on detect:
  - Exception: latch epc = pc, cause = {0, excCode} -> SAVE.
  - Interrupt: latch epc = pc, cause = {1, 27'b0, code} -> SAVE. The instruction at pc is not executed.
  - mret: -> RESTORE.
- SAVE (stall = 1), registers updated at end of cycle:
  - mepc = epc with bits1:0 cleared; mcause = cause.
  - MPIE = MIE, MIE = 0, MPP = priv, priv = 11.
  - -> VECTOR.
- VECTOR (stall = 1, redirect = 1):
  - redirectPC = {mtvec[31:2], 00}.
  - If mtvec[0] = 1 and the trap is an interrupt: redirectPC = base + 4*code.
  - -> IDLE.
- RESTORE (stall = 1, redirect = 1):
  - redirectPC = mepc.
  - End of cycle: MIE = MPIE, MPIE = 1, priv = MPP, MPP = 00.
  - -> IDLE.
- Latency: exception/interrupt = 3 cycles detect-to-redirect (IDLE, SAVE, VECTOR). mret = 2 cycles.
- csrWr is honoured only in IDLE with no detect. It is ignored in SAVE/VECTOR/RESTORE; trap updates always win.
- An exception that occurs while stall is high cannot be seen: instrValid is low in that state.
- mret executed in user mode is treated as an exception by the decoder; this block needs no special handling.

Test Plan:
- Reset: release reset -> priv 11, mtvec 0, csrRdData 0 for 0x300/0x341/0x342, stall 0, redirect 0.
- ECALL: pc 0x100, exception, excCode 8, mtvec 0x200 -> stall 3 cycles, redirect in cycle 3 to 0x200, mepc 0x100, mcause 8, MIE cleared, priv 11.
- Vectored timer interrupt: mtvec 0x401, mie 0x80, MIE 1, irq[1] raised -> mip bit7 set after 2 clocks; next instrValid at pc 0x50 -> redirect 0x41C, mcause 0x8000_0007, mepc 0x50.
- Priority: exception and pending external interrupt in the same cycle -> mcause = excCode (interrupt bit 0). Next instruction with interrupt still pending -> mcause 0x8000_000B.
- mret: mepc 0x123, MPIE 1, MPP 00 -> redirect 0x120 after 2 cycles, MIE 1, priv 00. A later ECALL gives mcause 8 with MPP 00 saved.
- Reset mid-SAVE: reset pulsed low in SAVE -> no redirect, state IDLE, mepc 0. CSR write to mtvec during VECTOR is ignored.
